i2c_slave_read_byte: RTL and testbench

//   Slave-side I2C byte receiver. It samples DATA_WIDTH bits from SDA, MSB first, on SCL rising edges.
//   It then drives the ACK/NACK bit on the 9th SCL clock.
//   It sits beside the slave byte transmitter under the slave controller FSM, which pulses enable and consumes data_out.

---
 rtl/i2c_slave_read_byte.sv | 119 +++++++++++
 tb/tb_i2c_slave_read_byte.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_read_byte.sv
// Slave-side I2C byte receiver: shifts DATA_WIDTH bits in MSB first on SCL rising
// edges, then drives ACK/NACK on the ninth clock through an open-drain style output.
module i2c_slave_read_byte #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  ack,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  finish,
   output logic                  abort,
   output logic                  busy,
   input  logic                  scl,
   input  logic                  sda_in,
   output logic                  sda_out
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      ACK_SETUP,
      ACK_HOLD
   } state_t;

   state_t                state;
   logic                  scl_last;
   logic                  sda_last;
   logic [CW-1:0]         counter;
   logic [DATA_WIDTH-2:0] shift;
   logic [DATA_WIDTH-1:0] shift_next;
   logic                  scl_rise;
   logic                  scl_fall;
   logic                  sda_change;

   assign scl_rise   = !scl_last && scl;
   assign scl_fall   = scl_last && !scl;
   // An SDA transition while SCL is steadily high is a START or STOP.
   assign sda_change = (sda_last != sda_in) && scl && scl_last;
   // Only the low DATA_WIDTH-1 bits are stored; the incoming bit completes the byte.
   assign shift_next = {shift, sda_in};
   assign busy       = (state != IDLE);

   // NOTE: sda_out is in the asynchronous reset so the bus is released the instant
   // reset asserts, even if the clock is stalled mid-ACK.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         scl_last   <= 1'b1;
         sda_last   <= 1'b1;
         counter    <= '0;
         shift      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         finish     <= 1'b0;
         abort      <= 1'b0;
         sda_out    <= 1'b1;
      end else begin
         scl_last   <= scl;
         sda_last   <= sda_in;
         data_valid <= 1'b0;
         finish     <= 1'b0;
         abort      <= 1'b0;

         case (state)
            IDLE: begin
               if (enable && !scl) begin
                  state   <= RECV;
                  counter <= '0;
                  sda_out <= 1'b1;
               end
            end

            RECV: begin
               if (sda_change) begin
                  abort   <= 1'b1;
                  counter <= '0;
                  state   <= IDLE;
               end else if (scl_rise) begin
                  shift <= shift_next[DATA_WIDTH-2:0];
                  if (counter == CW'(DATA_WIDTH - 1)) begin
                     counter    <= '0;
                     data_out   <= shift_next;
                     data_valid <= 1'b1;
                     state      <= ACK_SETUP;
                  end else begin
                     counter <= counter + 1'b1;
                  end
               end
            end

            ACK_SETUP: begin
               if (sda_change) begin
                  abort <= 1'b1;
                  state <= IDLE;
               end else if (scl_fall) begin
                  sda_out <= ~ack;
                  state   <= ACK_HOLD;
               end
            end

            ACK_HOLD: begin
               // This block owns SDA here, so line changes are not bus conditions.
               if (scl_fall) begin
                  sda_out <= 1'b1;
                  finish  <= 1'b1;
                  state   <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// Directed bench for i2c_slave_read_byte: a bit-banged master drives SCL/SDA with
// SDA modelled as a wired-AND of master and slave drivers.
module tb_i2c_slave_read_byte;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       ack;
   logic [7:0] data_out;
   logic       data_valid;
   logic       finish;
   logic       abort;
   logic       busy;
   logic       scl;
   logic       sda_in;
   logic       sda_out;
   logic       sda_m;

   int n_checks = 0;
   int n_fail   = 0;
   int dv_cnt   = 0;
   int fin_cnt  = 0;
   int ab_cnt   = 0;
   int excl_err = 0;
   logic [7:0] dv_data = 8'h00;

   always #5 clock = ~clock;

   assign sda_in = sda_m & sda_out;

   i2c_slave_read_byte #(.DATA_WIDTH(8)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable     (enable),
      .ack        (ack),
      .data_out   (data_out),
      .data_valid (data_valid),
      .finish     (finish),
      .abort      (abort),
      .busy       (busy),
      .scl        (scl),
      .sda_in     (sda_in),
      .sda_out    (sda_out)
   );

   always @(negedge clock) begin
      if (data_valid) begin
         dv_cnt  <= dv_cnt + 1;
         dv_data <= data_out;
      end
      if (finish) fin_cnt <= fin_cnt + 1;
      if (abort)  ab_cnt  <= ab_cnt + 1;
      if (int'(data_valid) + int'(finish) + int'(abort) > 1) excl_err <= excl_err + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_enable();
      enable = 1'b1;
      cycles(1);
      enable = 1'b0;
   endtask

   // Sends the top n bits of value, MSB first; returns with SCL low.
   task automatic send_bits(input logic [7:0] value, input int n);
      for (int i = 7; i >= 8 - n; i--) begin
         sda_m = value[i];
         cycles(4);
         scl = 1'b1;
         cycles(4);
         scl = 1'b0;
         cycles(1);
      end
   endtask

   // Ninth clock: master releases SDA, samples the slave drive while SCL is high,
   // then waits a bounded time for finish; optionally raises enable in that cycle.
   task automatic ack_clock(output logic got_sda, output logic seen, input logic chain);
      seen  = 1'b0;
      sda_m = 1'b1;
      cycles(4);
      scl = 1'b1;
      cycles(2);
      got_sda = sda_out;
      cycles(2);
      scl = 1'b0;
      for (int k = 0; k < 8; k++) begin
         cycles(1);
         if (finish) begin
            seen = 1'b1;
            if (chain) enable = 1'b1;
            break;
         end
      end
      cycles(1);
      enable = 1'b0;
   endtask

   initial begin
      logic s, fs;
      int d0, f0, a0;

      reset_n = 1'b0;
      enable  = 1'b0;
      ack     = 1'b0;
      scl     = 1'b1;
      sda_m   = 1'b1;
      cycles(3);
      check("rst_sda_out", 32'(sda_out), 32'h1);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_pulses", 32'({data_valid, finish, abort}), 32'h0);
      reset_n = 1'b1;
      cycles(2);

      // Byte 0xA5 with ACK
      scl = 1'b0;
      cycles(2);
      ack = 1'b1;
      d0 = dv_cnt;
      f0 = fin_cnt;
      pulse_enable();
      check("t1_busy", 32'(busy), 32'h1);
      send_bits(8'hA5, 8);
      check("t1_ack_after_8th_fall", 32'(sda_out), 32'h0);
      check("t1_dv_count", 32'(dv_cnt - d0), 32'h1);
      check("t1_dv_data", 32'(dv_data), 32'hA5);
      check("t1_data_out", 32'(data_out), 32'hA5);
      ack_clock(s, fs, 1'b0);
      check("t1_ack_in_9th", 32'(s), 32'h0);
      check("t1_finish_seen", 32'(fs), 32'h1);
      check("t1_fin_count", 32'(fin_cnt - f0), 32'h1);
      check("t1_busy_end", 32'(busy), 32'h0);
      check("t1_release", 32'(sda_out), 32'h1);

      // Byte 0x3C with NACK
      ack = 1'b0;
      pulse_enable();
      send_bits(8'h3C, 8);
      check("t2_nack_after_8th_fall", 32'(sda_out), 32'h1);
      ack_clock(s, fs, 1'b0);
      check("t2_nack_in_9th", 32'(s), 32'h1);
      check("t2_finish_seen", 32'(fs), 32'h1);
      check("t2_dv_data", 32'(dv_data), 32'h3C);

      // STOP after three bits (1,1,0): SDA rises while SCL is high
      d0 = dv_cnt;
      f0 = fin_cnt;
      a0 = ab_cnt;
      pulse_enable();
      send_bits(8'hC0, 3);
      cycles(2);
      scl = 1'b1;
      cycles(4);
      sda_m = 1'b1;
      cycles(3);
      check("t3_abort_count", 32'(ab_cnt - a0), 32'h1);
      check("t3_no_dv", 32'(dv_cnt - d0), 32'h0);
      check("t3_no_finish", 32'(fin_cnt - f0), 32'h0);
      check("t3_data_kept", 32'(data_out), 32'h3C);
      check("t3_idle", 32'(busy), 32'h0);

      // enable with SCL high is ignored; then a normal 0xFF byte
      pulse_enable();
      cycles(2);
      check("t4_ignored", 32'(busy), 32'h0);
      scl = 1'b0;
      cycles(2);
      ack = 1'b1;
      pulse_enable();
      check("t4_busy", 32'(busy), 32'h1);
      send_bits(8'hFF, 8);
      ack_clock(s, fs, 1'b0);
      check("t4_dv_data", 32'(dv_data), 32'hFF);
      check("t4_finish_seen", 32'(fs), 32'h1);

      // Reset asserted during ACK_HOLD
      pulse_enable();
      send_bits(8'h5A, 8);
      check("t5_in_ack_hold", 32'(sda_out), 32'h0);
      sda_m = 1'b1;
      cycles(4);
      scl = 1'b1;
      cycles(2);
      f0 = fin_cnt;
      #2 reset_n = 1'b0;
      #1;
      check("t5_sda_released", 32'(sda_out), 32'h1);
      check("t5_data_cleared", 32'(data_out), 32'h0);
      check("t5_busy", 32'(busy), 32'h0);
      cycles(2);
      scl = 1'b0;
      cycles(3);
      reset_n = 1'b1;
      cycles(3);
      check("t5_no_finish", 32'(fin_cnt - f0), 32'h0);
      check("t5_sda_idle", 32'(sda_out), 32'h1);

      // Back-to-back 0x01 then 0x80, second enable in the finish cycle
      d0 = dv_cnt;
      f0 = fin_cnt;
      pulse_enable();
      send_bits(8'h01, 8);
      check("t6_first_data", 32'(data_out), 32'h01);
      ack_clock(s, fs, 1'b1);
      check("t6_first_finish", 32'(fs), 32'h1);
      check("t6_chained_start", 32'(busy), 32'h1);
      send_bits(8'h80, 8);
      check("t6_second_data", 32'(dv_data), 32'h80);
      ack_clock(s, fs, 1'b0);
      check("t6_dv_count", 32'(dv_cnt - d0), 32'h2);
      check("t6_fin_count", 32'(fin_cnt - f0), 32'h2);

      cycles(2);
      check("pulses_exclusive", 32'(excl_err), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
